// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order fetch stage with a 2-entry instruction buffer
// Optional FETCH_ILLEGAL_HALT_EN: halt fetch after an unsupported opcode is buffered.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        decode_ready,
    output logic        illegal_op
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] tag;
    logic        inflight;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [2:0]  level;
    logic        pop;
    logic        push;
    logic        issue;
    logic        push_illegal;

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && decode_ready;

    // Entries held after this edge; the next request's data needs one free slot.
    assign level = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue = (state == RUN) && !redirect_valid && (level < 3'd2);

    // Responses landing while halted belong to requests past the illegal entry.
    assign push = inflight && (state != HALT) && !redirect_valid;

    assign imem_req  = issue;
    assign imem_addr = pc;
    assign instr     = fifo_instr[rd_ptr];
    assign instr_pc  = fifo_pc[rd_ptr];

`ifdef FETCH_ILLEGAL_HALT_EN
    logic fifo_illegal [2];

    function automatic logic op_unsupported(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b1100011, 7'b0000011, 7'b0010011,
            7'b0100011, 7'b1101111, 7'b0110111: return 1'b0;
            default:                            return 1'b1;
        endcase
    endfunction

    assign push_illegal = op_unsupported(imem_rdata[6:0]);
    assign illegal_op   = instr_valid && fifo_illegal[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_illegal[wr_ptr] <= push_illegal;
        end
    end
`else
    assign push_illegal = 1'b0;
    assign illegal_op   = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (push && push_illegal) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
        if (redirect_valid) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            tag      <= RESET_PC;
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc       <= {redirect_pc[31:2], 2'b00};
                inflight <= 1'b0;
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc  <= pc + 32'd4;
                    tag <= pc;
                end
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // Storage is not reset; count gates visibility of stale slots.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= tag;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_ILLEGAL_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready = 1'b0;
    logic        illegal_op;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .decode_ready   (decode_ready),
        .illegal_op     (illegal_op)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] salt;
    logic [31:0] illegal_addr;
    logic [6:0]  legal_ops [7] = '{7'b0110011, 7'b1100011, 7'b0000011, 7'b0010011,
                                   7'b0100011, 7'b1101111, 7'b0110111};

    // Reference model: program-order stream of addresses and instruction count bound.
    logic [31:0] exp_pc;
    logic [31:0] next_req;
    logic [31:0] redir_target;
    int          outstanding;
    int          since_redir;
    int          halt_in;
    logic        expect_redir_req;
    logic        halted;
    logic        drained;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic        obs_ill;

    function automatic logic op_legal(input logic [6:0] op);
        for (int i = 0; i < 7; i++) begin
            if (legal_ops[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = (a ^ salt) * 32'h9E37_79B1;
        if (a == illegal_addr) return {h[31:7], 7'b1110011};
        return {h[31:7], legal_ops[(h[9:7] == 3'd7) ? 3'd0 : h[9:7]]};
    endfunction

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        decode_ready = 1'($urandom_range(0, 1));
        repeat (cycles) begin
            @(posedge clk);
            #1 imem_rdata = $urandom;
        end
        rst_n = 1'b1;
        exp_pc = RESET_PC;
        next_req = RESET_PC;
        outstanding = 0;
        since_redir = 2;
        halt_in = 0;
        expect_redir_req = 1'b0;
        halted = 1'b0;
        drained = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req actual=%b expected=0", imem_req);
        end
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid actual=%b expected=0", instr_valid);
        end
        n_cmp++;
        if (illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_illegal actual=%b expected=0", illegal_op);
        end
        @(posedge clk);
        #1 imem_rdata = $urandom;
    endtask

    task automatic step(input logic ready, input logic redir, input logic [31:0] rpc);
        logic [31:0] w;
        decode_ready = ready;
        redirect_valid = redir;
        redirect_pc = rpc;
        @(negedge clk);
        obs_req = imem_req;
        obs_addr = imem_addr;
        obs_valid = instr_valid;
        obs_pc = instr_pc;
        obs_ill = illegal_op;
        if (expect_redir_req && !redir) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== redir_target) begin
                n_fail++;
                $display("FAIL redirect_issue req=%b addr=%h expected req=1 addr=%h",
                         imem_req, imem_addr, redir_target);
            end
        end
        expect_redir_req = 1'b0;
        if (redir) begin
            n_cmp++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL redirect_noreq actual=%b expected=0", imem_req);
            end
            redir_target = {rpc[31:2], 2'b00};
            exp_pc = redir_target;
            next_req = redir_target;
            outstanding = 0;
            since_redir = 0;
            expect_redir_req = 1'b1;
            halt_in = 0;
            halted = 1'b0;
            drained = 1'b0;
        end else begin
            if (since_redir < 2) begin
                n_cmp++;
                if (instr_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL redirect_latency valid=%b expected=0", instr_valid);
                end
            end
            since_redir++;
            if (instr_valid === 1'b1) begin
                w = mem_word(exp_pc);
                n_cmp++;
                if (drained || instr_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL instr_pc actual=%h expected=%h after_halt=%b",
                             instr_pc, exp_pc, drained);
                end
                n_cmp++;
                if (instr !== w) begin
                    n_fail++;
                    $display("FAIL instr_word actual=%h expected=%h", instr, w);
                end
                n_cmp++;
                if (illegal_op !== (HALT_EN & ~op_legal(w[6:0]))) begin
                    n_fail++;
                    $display("FAIL illegal_op actual=%b expected=%b",
                             illegal_op, HALT_EN & ~op_legal(w[6:0]));
                end
                if (ready) begin
`ifdef FETCH_ILLEGAL_HALT_EN
                    if (!op_legal(w[6:0])) drained = 1'b1;
`endif
                    exp_pc = exp_pc + 32'd4;
                    outstanding--;
                end
            end else begin
                n_cmp++;
                if (illegal_op !== 1'b0) begin
                    n_fail++;
                    $display("FAIL illegal_idle actual=%b expected=0", illegal_op);
                end
            end
            if (imem_req === 1'b1) begin
                n_cmp++;
                if (halted || imem_addr !== next_req) begin
                    n_fail++;
                    $display("FAIL imem_addr actual=%h expected=%h halted=%b",
                             imem_addr, next_req, halted);
                end
                outstanding++;
                n_cmp++;
                if (outstanding > 2) begin
                    n_fail++;
                    $display("FAIL occupancy actual=%0d expected<=2", outstanding);
                end
`ifdef FETCH_ILLEGAL_HALT_EN
                w = mem_word(next_req);
                if (!op_legal(w[6:0]) && halt_in == 0 && !halted) halt_in = 2;
`endif
                next_req = next_req + 32'd4;
            end
            if (halt_in > 0) begin
                halt_in--;
                if (halt_in == 0) halted = 1'b1;
            end
        end
        @(posedge clk);
        #1 imem_rdata = obs_req ? mem_word(obs_addr) : $urandom;
    endtask

    task automatic test_reset();
        salt = $urandom;
        illegal_addr = 32'h1;
        do_reset(3);
        step(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req req=%b addr=%h expected req=1 addr=%h", obs_req, obs_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        salt = $urandom;
        illegal_addr = 32'h1;
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'h0);
            n_cmp++;
            if (obs_req !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_req step=%0d actual=%b expected=1", i, obs_req);
            end
            n_cmp++;
            if (obs_valid !== (i >= 2)) begin
                n_fail++;
                $display("FAIL stream_valid step=%0d actual=%b expected=%b", i, obs_valid, i >= 2);
            end
            if (i >= 2) begin
                n_cmp++;
                if (obs_pc !== RESET_PC + 32'(4 * (i - 2))) begin
                    n_fail++;
                    $display("FAIL stream_pc step=%0d actual=%h expected=%h",
                             i, obs_pc, RESET_PC + 32'(4 * (i - 2)));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        salt = $urandom;
        illegal_addr = 32'h1;
        do_reset(1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        held = exp_pc;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (obs_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_req step=%0d actual=%b expected=0", i, obs_req);
            end
            n_cmp++;
            if (obs_valid !== 1'b1 || obs_pc !== held) begin
                n_fail++;
                $display("FAIL stall_head step=%0d valid=%b pc=%h expected valid=1 pc=%h",
                         i, obs_valid, obs_pc, held);
            end
        end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_redirect();
        salt = $urandom;
        illegal_addr = 32'h1;
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0103);
        step(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL redirect_100 req=%b addr=%h expected req=1 addr=00000100", obs_req, obs_addr);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0203);
        step(1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL redirect_200 req=%b addr=%h expected req=1 addr=00000200", obs_req, obs_addr);
        end
        for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        salt = $urandom;
        illegal_addr = 32'h1;
        do_reset(1);
        step(1'b1, 1'b1, 32'hFFFF_FFF7);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (i == 2) begin
                n_cmp++;
                if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
                    n_fail++;
                    $display("FAIL wrap_top req=%b addr=%h expected req=1 addr=fffffffc", obs_req, obs_addr);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (obs_req !== 1'b1 || obs_addr !== 32'h0000_0000) begin
                    n_fail++;
                    $display("FAIL wrap_zero req=%b addr=%h expected req=1 addr=00000000", obs_req, obs_addr);
                end
            end
        end
    endtask

    task automatic test_illegal();
        int ill_seen;
        int pc12_seen;
        int late_req;
        int late_valid;
        int rec_valid;
        salt = $urandom;
        illegal_addr = 32'h8;
        ill_seen = 0;
        pc12_seen = 0;
        late_req = 0;
        late_valid = 0;
        rec_valid = 0;
        do_reset(1);
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (obs_valid && obs_ill && obs_pc == 32'h8) ill_seen++;
            if (obs_valid && obs_pc == 32'hC) pc12_seen++;
            if (i >= 5) begin
                if (obs_req) late_req++;
                if (obs_valid) late_valid++;
            end
        end
`ifdef FETCH_ILLEGAL_HALT_EN
        n_cmp++;
        if (ill_seen != 1 || pc12_seen != 0) begin
            n_fail++;
            $display("FAIL halt_present ill_seen=%0d pc12_seen=%0d expected 1 and 0", ill_seen, pc12_seen);
        end
        n_cmp++;
        if (late_req != 0 || late_valid != 0) begin
            n_fail++;
            $display("FAIL halt_quiet req_cycles=%0d valid_cycles=%0d expected 0 and 0", late_req, late_valid);
        end
`else
        n_cmp++;
        if (ill_seen != 0 || pc12_seen != 1) begin
            n_fail++;
            $display("FAIL noh_present ill_seen=%0d pc12_seen=%0d expected 0 and 1", ill_seen, pc12_seen);
        end
        n_cmp++;
        if (late_valid != 9) begin
            n_fail++;
            $display("FAIL noh_flow valid_cycles=%0d expected 9", late_valid);
        end
`endif
        step(1'b1, 1'b1, 32'h0000_0040);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (obs_valid) rec_valid++;
        end
        n_cmp++;
        if (rec_valid != 4) begin
            n_fail++;
            $display("FAIL redirect_recover valid_cycles=%0d expected 4", rec_valid);
        end
    endtask

    task automatic test_reset_mid();
        salt = $urandom;
        illegal_addr = 32'h1;
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (i == 2) begin
                n_cmp++;
                if (obs_valid !== 1'b1 || obs_pc !== RESET_PC) begin
                    n_fail++;
                    $display("FAIL mid_reset_first valid=%b pc=%h expected valid=1 pc=%h",
                             obs_valid, obs_pc, RESET_PC);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        salt = $urandom;
        illegal_addr = 32'h1;
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) begin
                do_reset(1);
            end else begin
                t = $urandom;
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | {28'h0, t[3:0]};
                step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 6), t);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
